// File: rtl/rtype_mc_controller_pkg.sv
// Shared definitions for the multi-cycle R-type controller: state encoding,
// instruction field constants, ALU operation codes and the legality check.
package rtype_mc_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_NOR = 3'b111;

   // True for the funct codes this datapath can execute.
   function automatic logic is_legal_funct(input logic [5:0] fn);
      logic ok;
      case (fn)
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
         FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL: ok = 1'b1;
         default:                               ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rtype_mc_controller_alu_control.sv
// Combinational funct-to-ALU-operation decoder. Unknown codes map to AND;
// the sequencer never reaches EXEC with an unknown code anyway.
module rtype_mc_controller_alu_control
   import rtype_mc_controller_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op
);

   // Translate the function field into the ALU operation select.
   always_comb begin
      alu_op = ALU_AND;
      case (funct)
         FN_ADD, FN_ADDU:         alu_op = ALU_ADD;
         FN_SUB, FN_SUBU, FN_SLT: alu_op = ALU_SUB;
         FN_AND:                  alu_op = ALU_AND;
         FN_OR:                   alu_op = ALU_OR;
         FN_NOR:                  alu_op = ALU_NOR;
         FN_SLL:                  alu_op = ALU_SLL;
         FN_SRL:                  alu_op = ALU_SRL;
         default:                 alu_op = ALU_AND;
      endcase
   end

endmodule

// File: rtl/rtype_mc_controller.sv
// Multi-cycle sequencer for the R-type datapath. Steps each instruction
// through FETCH, DECODE, EXEC and WB, traps on illegal encodings and counts
// retired instructions. All outputs except ir_we come straight from flops
// loaded with the decode of the upcoming state, so they line up with the
// state register and never see run combinationally.
module rtype_mc_controller
   import rtype_mc_controller_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             imem_ready,
   input  logic [31:0]      instr,
   output logic             imem_req,
   output logic             ir_we,
   output logic [2:0]       alu_op,
   output logic             shamt_sel,
   output logic             slt_sel,
   output logic             reg_write,
   output logic             pc_en,
   output logic             busy,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   state_t     state_next;
   logic [5:0] opcode_q;
   logic [5:0] funct_q;
   logic [2:0] dec_op;
   logic       fetch_hit;
   logic       legal;
   logic       alu_active_next;
   logic       is_shift;
   logic       is_slt;
   logic       unused_instr_bits;

   // Only the opcode and funct fields matter to the controller.
   assign unused_instr_bits = ^instr[25:6];

   assign fetch_hit       = (state == ST_FETCH) && imem_ready;
   assign ir_we           = fetch_hit;
   assign legal           = (opcode_q == OP_RTYPE) && is_legal_funct(funct_q);
   assign alu_active_next = (state_next == ST_EXEC) || (state_next == ST_WB);
   assign is_shift        = (funct_q == FN_SLL) || (funct_q == FN_SRL);
   assign is_slt          = (funct_q == FN_SLT);

   rtype_mc_controller_alu_control u_alu_control (
      .funct  (funct_q),
      .alu_op (dec_op)
   );

   // Next-state selection for the instruction sequencer.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (run) state_next = ST_FETCH;
         ST_FETCH:  if (imem_ready) state_next = ST_DECODE;
         ST_DECODE: state_next = legal ? ST_EXEC : ST_TRAP;
         ST_EXEC:   state_next = ST_WB;
         ST_WB:     state_next = run ? ST_FETCH : ST_IDLE;
         ST_TRAP:   state_next = ST_TRAP;
         default:   state_next = ST_IDLE;
      endcase
   end

   // State register, field latch, registered output decodes and retire counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         opcode_q  <= 6'd0;
         funct_q   <= 6'd0;
         imem_req  <= 1'b0;
         alu_op    <= ALU_AND;
         shamt_sel <= 1'b0;
         slt_sel   <= 1'b0;
         reg_write <= 1'b0;
         pc_en     <= 1'b0;
         busy      <= 1'b0;
         illegal   <= 1'b0;
         retired   <= '0;
      end else begin
         state <= state_next;
         if (fetch_hit) begin
            opcode_q <= instr[31:26];
            funct_q  <= instr[5:0];
         end
         imem_req  <= (state_next == ST_FETCH);
         alu_op    <= alu_active_next ? dec_op : ALU_AND;
         shamt_sel <= alu_active_next && is_shift;
         slt_sel   <= alu_active_next && is_slt;
         reg_write <= (state_next == ST_WB);
         pc_en     <= (state_next == ST_WB);
         busy      <= (state_next != ST_IDLE) && (state_next != ST_TRAP);
         illegal   <= (state_next == ST_TRAP);
         if (state == ST_WB) begin
            retired <= retired + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rtype_mc_controller.sv
// Bench for the multi-cycle R-type controller: a hand-filled table of
// instructions, scripted corner sequences and random instructions, all
// checked cycle by cycle against the instruction timeline.
module tb_rtype_mc_controller;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic [31:0] word;
      logic        legal;
      logic [2:0]  op;
      logic        shamt;
      logic        slt;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             run;
   logic             imem_ready;
   logic [31:0]      instr;
   logic             imem_req;
   logic             ir_we;
   logic [2:0]       alu_op;
   logic             shamt_sel;
   logic             slt_sel;
   logic             reg_write;
   logic             pc_en;
   logic             busy;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   int               total = 0;
   int               bad = 0;
   logic [CNT_W-1:0] model_cnt;
   vec_t             tbl[10];
   logic [5:0]       legal_fn[10];

   rtype_mc_controller #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .imem_ready (imem_ready),
      .instr      (instr),
      .imem_req   (imem_req),
      .ir_we      (ir_we),
      .alu_op     (alu_op),
      .shamt_sel  (shamt_sel),
      .slt_sel    (slt_sel),
      .reg_write  (reg_write),
      .pc_en      (pc_en),
      .busy       (busy),
      .illegal    (illegal),
      .retired    (retired)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] mkR(input logic [5:0] fn);
      return {6'b000000, 5'd4, 5'd5, 5'd2, 5'd3, fn};
   endfunction

   // Expected behaviour of one instruction word, straight from the opcode/funct table.
   function automatic vec_t refModel(input logic [31:0] w);
      vec_t v;
      v.word  = w;
      v.legal = 1'b0;
      v.op    = 3'b000;
      v.shamt = 1'b0;
      v.slt   = 1'b0;
      if (w[31:26] == 6'b000000) begin
         case (w[5:0])
            6'b100000, 6'b100001: begin v.legal = 1'b1; v.op = 3'b010; end
            6'b100010, 6'b100011: begin v.legal = 1'b1; v.op = 3'b100; end
            6'b101010: begin v.legal = 1'b1; v.op = 3'b100; v.slt = 1'b1; end
            6'b100100: begin v.legal = 1'b1; v.op = 3'b000; end
            6'b100101: begin v.legal = 1'b1; v.op = 3'b001; end
            6'b100111: begin v.legal = 1'b1; v.op = 3'b111; end
            6'b000000: begin v.legal = 1'b1; v.op = 3'b110; v.shamt = 1'b1; end
            6'b000010: begin v.legal = 1'b1; v.op = 3'b101; v.shamt = 1'b1; end
            default: v.legal = 1'b0;
         endcase
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic stepCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic checkQuiet(input string tag);
      checkOutput({tag, "_regw"}, 32'(reg_write), 32'd0);
      checkOutput({tag, "_pcen"}, 32'(pc_en), 32'd0);
      checkOutput({tag, "_aluop"}, 32'(alu_op), 32'd0);
      checkOutput({tag, "_shamt"}, 32'(shamt_sel), 32'd0);
      checkOutput({tag, "_slt"}, 32'(slt_sel), 32'd0);
   endtask

   task automatic doReset;
      reset = 1'b1;
      run = 1'b0;
      imem_ready = 1'b0;
      instr = 32'd0;
      stepCycle;
      stepCycle;
      reset = 1'b0;
      model_cnt = '0;
      checkQuiet("rst");
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_req", 32'(imem_req), 32'd0);
      checkOutput("rst_ill", 32'(illegal), 32'd0);
      checkOutput("rst_irwe", 32'(ir_we), 32'd0);
      checkOutput("rst_ret", 32'(retired), 32'd0);
   endtask

   // From IDLE, raise run and advance into the first FETCH cycle.
   task automatic startRun;
      run = 1'b1;
      #1;
      checkOutput("idle_req", 32'(imem_req), 32'd0);
      stepCycle;
   endtask

   // Drive one instruction starting in a FETCH cycle and check every cycle of it.
   task automatic applyStimulus(input vec_t v, input int waits, input logic run_after);
      for (int w = 0; w < waits; w++) begin
         imem_ready = 1'b0;
         instr = $urandom;
         #1;
         checkOutput("wait_req", 32'(imem_req), 32'd1);
         checkOutput("wait_irwe", 32'(ir_we), 32'd0);
         checkOutput("wait_busy", 32'(busy), 32'd1);
         checkQuiet("wait");
         stepCycle;
      end
      imem_ready = 1'b1;
      instr = v.word;
      #1;
      checkOutput("fetch_req", 32'(imem_req), 32'd1);
      checkOutput("fetch_irwe", 32'(ir_we), 32'd1);
      checkQuiet("fetch");
      stepCycle;
      imem_ready = 1'($urandom_range(0, 1));
      instr = $urandom;
      #1;
      checkOutput("dec_req", 32'(imem_req), 32'd0);
      checkOutput("dec_irwe", 32'(ir_we), 32'd0);
      checkOutput("dec_busy", 32'(busy), 32'd1);
      checkQuiet("dec");
      stepCycle;
      if (v.legal) begin
         run = run_after;
         imem_ready = 1'($urandom_range(0, 1));
         #1;
         checkOutput("exec_aluop", 32'(alu_op), 32'(v.op));
         checkOutput("exec_shamt", 32'(shamt_sel), 32'(v.shamt));
         checkOutput("exec_slt", 32'(slt_sel), 32'(v.slt));
         checkOutput("exec_regw", 32'(reg_write), 32'd0);
         checkOutput("exec_pcen", 32'(pc_en), 32'd0);
         checkOutput("exec_irwe", 32'(ir_we), 32'd0);
         stepCycle;
         checkOutput("wb_aluop", 32'(alu_op), 32'(v.op));
         checkOutput("wb_shamt", 32'(shamt_sel), 32'(v.shamt));
         checkOutput("wb_slt", 32'(slt_sel), 32'(v.slt));
         checkOutput("wb_regw", 32'(reg_write), 32'd1);
         checkOutput("wb_pcen", 32'(pc_en), 32'd1);
         checkOutput("wb_ret", 32'(retired), 32'(model_cnt));
         stepCycle;
         model_cnt = model_cnt + 1'b1;
         imem_ready = 1'b0;
         #1;
         checkOutput("post_ret", 32'(retired), 32'(model_cnt));
         checkOutput("post_req", 32'(imem_req), 32'(run_after));
         checkOutput("post_busy", 32'(busy), 32'(run_after));
         checkQuiet("post");
      end else begin
         for (int k = 0; k < 4; k++) begin
            run = 1'b1;
            imem_ready = 1'($urandom_range(0, 1));
            #1;
            checkOutput("trap_ill", 32'(illegal), 32'd1);
            checkOutput("trap_busy", 32'(busy), 32'd0);
            checkOutput("trap_req", 32'(imem_req), 32'd0);
            checkOutput("trap_irwe", 32'(ir_we), 32'd0);
            checkOutput("trap_ret", 32'(retired), 32'(model_cnt));
            checkQuiet("trap");
            stepCycle;
         end
      end
   endtask

   initial begin
      vec_t rv;
      logic [31:0] tmp;
      logic ra;

      legal_fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                   6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010};
      tbl[0] = '{32'h00851020,        1'b1, 3'b010, 1'b0, 1'b0};
      tbl[1] = '{mkR(6'b100010),      1'b1, 3'b100, 1'b0, 1'b0};
      tbl[2] = '{mkR(6'b100100),      1'b1, 3'b000, 1'b0, 1'b0};
      tbl[3] = '{mkR(6'b100101),      1'b1, 3'b001, 1'b0, 1'b0};
      tbl[4] = '{mkR(6'b100111),      1'b1, 3'b111, 1'b0, 1'b0};
      tbl[5] = '{mkR(6'b101010),      1'b1, 3'b100, 1'b0, 1'b1};
      tbl[6] = '{mkR(6'b000000),      1'b1, 3'b110, 1'b1, 1'b0};
      tbl[7] = '{mkR(6'b000010),      1'b1, 3'b101, 1'b1, 1'b0};
      tbl[8] = '{mkR(6'b100001),      1'b1, 3'b010, 1'b0, 1'b0};
      tbl[9] = '{mkR(6'b100011),      1'b1, 3'b100, 1'b0, 1'b0};

      $display("[TB] table vectors");
      doReset;
      startRun;
      for (int i = 0; i < 10; i++) applyStimulus(tbl[i], 0, 1'b1);

      $display("[TB] fetch wait of three cycles");
      applyStimulus(tbl[0], 3, 1'b1);

      $display("[TB] run dropped during EXEC");
      applyStimulus(tbl[1], 0, 1'b0);
      run = 1'b0;
      for (int k = 0; k < 2; k++) begin
         stepCycle;
         checkOutput("idle_busy", 32'(busy), 32'd0);
         checkOutput("idle_req2", 32'(imem_req), 32'd0);
      end
      run = 1'b1;
      stepCycle;
      checkOutput("rerun_req", 32'(imem_req), 32'd1);
      checkOutput("rerun_busy", 32'(busy), 32'd1);

      $display("[TB] reset in the middle of FETCH");
      imem_ready = 1'b0;
      reset = 1'b1;
      stepCycle;
      reset = 1'b0;
      model_cnt = '0;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_req", 32'(imem_req), 32'd0);
      checkOutput("midrst_ret", 32'(retired), 32'd0);
      stepCycle;
      checkOutput("midrst_fetch", 32'(imem_req), 32'd1);

      $display("[TB] illegal encodings");
      applyStimulus(refModel(32'h8C820000), 1, 1'b1);
      doReset;
      startRun;
      applyStimulus(tbl[2], 0, 1'b1);
      applyStimulus(refModel(mkR(6'b001000)), 0, 1'b1);
      reset = 1'b1;
      stepCycle;
      reset = 1'b0;
      model_cnt = '0;
      checkOutput("traprst_ill", 32'(illegal), 32'd0);
      checkOutput("traprst_ret", 32'(retired), 32'd0);
      stepCycle;
      checkOutput("traprst_fetch", 32'(imem_req), 32'd1);
      applyStimulus(refModel({6'b000001, 20'h12345, 6'b100000}), 0, 1'b1);

      $display("[TB] counter wrap");
      doReset;
      startRun;
      for (int i = 0; i < 16; i++) applyStimulus(tbl[i % 10], 0, 1'b1);
      checkOutput("wrap_zero", 32'(retired), 32'd0);

      $display("[TB] random instructions");
      for (int i = 0; i < 60; i++) begin
         tmp = $urandom;
         if ($urandom_range(0, 9) < 8)
            rv = refModel({6'b000000, tmp[19:0], legal_fn[$urandom_range(0, 9)]});
         else if ($urandom_range(0, 1) == 1)
            rv = refModel({6'b000000, tmp[25:0]});
         else
            rv = refModel(tmp);
         ra = ($urandom_range(0, 3) != 0);
         applyStimulus(rv, int'($urandom_range(0, 3)), ra);
         if (!rv.legal) begin
            doReset;
            startRun;
         end else if (!ra) begin
            run = 1'b1;
            stepCycle;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
